// File: rtl/mini_ex_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_ex_core_pkg
// Description : Shared types and widths for the mini_ex_core execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mini_ex_core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9,
        MUL  = 4'd10
    } t_alu_op;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } t_mul_state;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] Reg1Val;
        logic [DATA_WIDTH-1:0] Reg2Val;
    } t_rg_val;

    typedef struct packed {
        logic                  Valid;
        t_alu_op               AluOp;
        logic [REG_ADDR_W-1:0] Src1Reg;
        logic [REG_ADDR_W-1:0] Src2Reg;
        logic [REG_ADDR_W-1:0] DstReg;
        logic                  WrEn;
        logic                  UseImm;
        logic [DATA_WIDTH-1:0] Imm;
    } t_exe_ctrl;

    typedef struct packed {
        logic                  Valid;
        logic                  WrEn;
        logic [REG_ADDR_W-1:0] DstReg;
        logic [DATA_WIDTH-1:0] Value;
    } t_exe_res;

endpackage
`default_nettype wire

// File: rtl/mini_ex_core_exe_if.sv
`default_nettype none
// ============================================================================
// Module      : mini_ex_core_exe_if
// Description : Q101H operand/control inputs and Q102H result of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mini_ex_core_exe_if;
    import mini_ex_core_pkg::*;

    t_rg_val   ValRegsQ101H;
    t_exe_ctrl CtrlQ101H;
    logic      StallQ101H;
    t_exe_res  ExeResultQ102H;

    modport master (
        output ValRegsQ101H,
        output CtrlQ101H,
        input  StallQ101H,
        input  ExeResultQ102H
    );

    modport slave (
        input  ValRegsQ101H,
        input  CtrlQ101H,
        output StallQ101H,
        output ExeResultQ102H
    );

endinterface
`default_nettype wire

// File: rtl/mini_ex_core_mul.sv
`default_nettype none
// ============================================================================
// Module      : mini_ex_core_mul
// Description : Iterative unsigned shift-add multiplier, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_ex_core_mul
    import mini_ex_core_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  Start_i,
    input  logic [DATA_WIDTH-1:0] OpA_i,
    input  logic [DATA_WIDTH-1:0] OpB_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] Result_o
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_WIDTH-1);

    t_mul_state            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] acc_q,   acc_d;
    logic [DATA_WIDTH-1:0] mcnd_q,  mcnd_d;
    logic [DATA_WIDTH-1:0] mplr_q,  mplr_d;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcnd_q  <= '0;
            mplr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcnd_q  <= mcnd_d;
            mplr_q  <= mplr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcnd_d  = mcnd_q;
        mplr_d  = mplr_q;
        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    mcnd_d  = OpA_i;
                    mplr_d  = OpB_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d  = acc_q + (mplr_q[0] ? mcnd_q : '0);
                mcnd_d = mcnd_q << 1;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result is the accumulator including the last partial product, so the
    // top can register it on the same edge that returns the FSM to IDLE.
    assign Busy_o   = (state_q == BUSY);
    assign Done_o   = (state_q == BUSY) && (cnt_q == c_CNT_LAST);
    assign Result_o = acc_d;

endmodule
`default_nettype wire

// File: rtl/mini_ex_core_exe.sv
`default_nettype none
// ============================================================================
// Module      : mini_ex_core_exe
// Description : Execute stage: operand forwarding, ALU, iterative MUL, Q102H result.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_ex_core_exe
    import mini_ex_core_pkg::*;
(
    input  logic                     Clock,
    input  logic                     Rst,
    mini_ex_core_exe_if.slave        exe_bus
);

    t_exe_ctrl             w_ctrl;
    t_rg_val               w_regs;
    t_exe_res              res_q, res_d;
    logic [REG_ADDR_W-1:0] mul_dst_q, mul_dst_d;
    logic                  mul_wren_q, mul_wren_d;

    logic                  w_fwd1, w_fwd2;
    logic [DATA_WIDTH-1:0] w_op1, w_op2, w_alu;
    logic [CNT_W-1:0]      w_shamt;
    logic                  w_mul_start, w_mul_busy, w_mul_done;
    logic [DATA_WIDTH-1:0] w_mul_res;

    assign w_ctrl = exe_bus.CtrlQ101H;
    assign w_regs = exe_bus.ValRegsQ101H;

    // x0 never counts as a forwarding target, so a result with DstReg 0 is invisible here.
    assign w_fwd1 = res_q.Valid && res_q.WrEn && (res_q.DstReg == w_ctrl.Src1Reg)
                    && (w_ctrl.Src1Reg != '0);
    assign w_fwd2 = res_q.Valid && res_q.WrEn && (res_q.DstReg == w_ctrl.Src2Reg)
                    && (w_ctrl.Src2Reg != '0);

    assign w_op1 = (w_ctrl.Src1Reg == '0) ? '0 :
                   (w_fwd1 ? res_q.Value : w_regs.Reg1Val);
    assign w_op2 = w_ctrl.UseImm ? w_ctrl.Imm :
                   ((w_ctrl.Src2Reg == '0) ? '0 :
                   (w_fwd2 ? res_q.Value : w_regs.Reg2Val));

    assign w_shamt = w_op2[CNT_W-1:0];

    always_comb begin
        w_alu = '0;
        case (w_ctrl.AluOp)
            ADD:     w_alu = w_op1 + w_op2;
            SUB:     w_alu = w_op1 - w_op2;
            AND:     w_alu = w_op1 & w_op2;
            OR:      w_alu = w_op1 | w_op2;
            XOR:     w_alu = w_op1 ^ w_op2;
            SLL:     w_alu = w_op1 << w_shamt;
            SRL:     w_alu = w_op1 >> w_shamt;
            SRA:     w_alu = $unsigned($signed(w_op1) >>> w_shamt);
            SLT:     w_alu = DATA_WIDTH'($signed(w_op1) < $signed(w_op2));
            SLTU:    w_alu = DATA_WIDTH'(w_op1 < w_op2);
            default: w_alu = '0;
        endcase
    end

    // Control is ignored while busy: the held MUL must not start a second time.
    assign w_mul_start = w_ctrl.Valid && (w_ctrl.AluOp == MUL) && !w_mul_busy;

    mini_ex_core_mul u_mul (
        .Clock    (Clock),
        .Rst      (Rst),
        .Start_i  (w_mul_start),
        .OpA_i    (w_op1),
        .OpB_i    (w_op2),
        .Busy_o   (w_mul_busy),
        .Done_o   (w_mul_done),
        .Result_o (w_mul_res)
    );

    assign exe_bus.StallQ101H = w_mul_start || (w_mul_busy && !w_mul_done);

    always_comb begin
        res_d       = res_q;
        res_d.Valid = 1'b0;
        mul_dst_d   = mul_dst_q;
        mul_wren_d  = mul_wren_q;
        if (w_mul_busy) begin
            if (w_mul_done) begin
                res_d.Valid  = 1'b1;
                res_d.WrEn   = mul_wren_q;
                res_d.DstReg = mul_dst_q;
                res_d.Value  = w_mul_res;
            end
        end else if (w_mul_start) begin
            mul_dst_d  = w_ctrl.DstReg;
            mul_wren_d = w_ctrl.WrEn;
        end else if (w_ctrl.Valid) begin
            res_d.Valid  = 1'b1;
            res_d.WrEn   = w_ctrl.WrEn;
            res_d.DstReg = w_ctrl.DstReg;
            res_d.Value  = w_alu;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            res_q      <= '0;
            mul_dst_q  <= '0;
            mul_wren_q <= 1'b0;
        end else begin
            res_q      <= res_d;
            mul_dst_q  <= mul_dst_d;
            mul_wren_q <= mul_wren_d;
        end
    end

    assign exe_bus.ExeResultQ102H = res_q;

endmodule
`default_nettype wire

// File: tb/tb_mini_ex_core_exe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_ex_core_exe
// Description : Self-checking bench: directed vectors, MUL/reset sequences, random stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_ex_core_exe;
    import mini_ex_core_pkg::*;

    logic Clock = 1'b0;
    logic Rst   = 1'b1;
    always #5 Clock = ~Clock;

    mini_ex_core_exe_if bus ();

    mini_ex_core_exe dut (
        .Clock   (Clock),
        .Rst     (Rst),
        .exe_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        t_alu_op     op;
        logic [4:0]  s1, s2, d;
        logic        we, ui;
        logic [31:0] imm, r1, r2, exp;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] val;
    } exp_t;

    exp_t expq[$];
    bit   mon_en = 1'b0;
    int   nres   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input t_alu_op op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic we, input logic ui,
                         input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2);
        t_exe_ctrl c;
        c.Valid   = 1'b1;
        c.AluOp   = op;
        c.Src1Reg = s1;
        c.Src2Reg = s2;
        c.DstReg  = d;
        c.WrEn    = we;
        c.UseImm  = ui;
        c.Imm     = imm;
        bus.CtrlQ101H             = c;
        bus.ValRegsQ101H.Reg1Val  = r1;
        bus.ValRegsQ101H.Reg2Val  = r2;
    endtask

    task automatic idle();
        bus.CtrlQ101H    = '0;
        bus.ValRegsQ101H = '0;
    endtask

    // Architectural meaning of each op, independent of any datapath structure.
    function automatic logic [31:0] model(input t_alu_op op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            AND:  r = a & b;
            OR:   r = a | b;
            XOR:  r = a ^ b;
            SLL:  r = a << b[4:0];
            SRL:  r = a >> b[4:0];
            SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: r = (a < b) ? 32'd1 : 32'd0;
            MUL:  r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(negedge Clock) begin
        if (mon_en && bus.ExeResultQ102H.Valid) begin
            nres++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_extra actual=%h required=none", bus.ExeResultQ102H);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("rnd_result", {25'd0, bus.ExeResultQ102H.WrEn, bus.ExeResultQ102H.DstReg,
                      bus.ExeResultQ102H.Value}, {25'd0, e});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab[14];
        logic [31:0] rf[32];
        logic [31:0] rf_prev[32];
        logic [31:0] drv[32];
        int          stall_cnt, lat, nvalid, nissued;
        bit          held, st, b2b;
        t_exe_res    got;

        tab[0]  = '{ADD,  5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0, 32'd5,        32'd7,        32'd12};
        tab[1]  = '{ADD,  5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 32'd4, 32'h0000DEAD, 32'd9,        32'd4};
        tab[2]  = '{SLT,  5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd1,        32'd1};
        tab[3]  = '{SLTU, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd1,        32'd0};
        tab[4]  = '{SRA,  5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'd0, 32'h80000000, 32'd4,        32'hF8000000};
        tab[5]  = '{SUB,  5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 32'd0, 32'd0,        32'd1,        32'hFFFFFFFF};
        tab[6]  = '{SLL,  5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'd0, 32'd1,        32'h25,       32'd32};
        tab[7]  = '{SRL,  5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'd0, 32'h80000000, 32'd31,       32'd1};
        tab[8]  = '{XOR,  5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
        tab[9]  = '{AND,  5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 32'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        tab[10] = '{OR,   5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
        tab[11] = '{ADD,  5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'd0, 32'd3,        32'd4,        32'd7};
        tab[12] = '{ADD,  5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 32'd0, 32'd9,        32'h1234,     32'd9};
        tab[13] = '{SLT,  5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 32'd0, 32'd1,        32'hFFFFFFFF, 32'd0};

        idle();
        Rst = 1'b1;
        repeat (3) @(posedge Clock);
        #1 Rst = 1'b0;
        @(negedge Clock);
        check("reset_result", {25'd0, bus.ExeResultQ102H}, 64'd0);
        check("reset_stall", {63'd0, bus.StallQ101H}, 64'd0);

        @(posedge Clock); #1;
        for (int i = 0; i < 14; i++) begin
            drive(tab[i].op, tab[i].s1, tab[i].s2, tab[i].d, tab[i].we, tab[i].ui,
                  tab[i].imm, tab[i].r1, tab[i].r2);
            @(negedge Clock);
            check($sformatf("vec%0d_stall", i), {63'd0, bus.StallQ101H}, 64'd0);
            @(posedge Clock); #1;
            idle();
            @(negedge Clock);
            check($sformatf("vec%0d_result", i),
                  {25'd0, bus.ExeResultQ102H.Valid, bus.ExeResultQ102H.WrEn,
                   bus.ExeResultQ102H.DstReg, bus.ExeResultQ102H.Value},
                  {25'd0, 1'b1, tab[i].we, tab[i].d, tab[i].exp});
            @(posedge Clock); #1;
        end
        @(negedge Clock);
        check("bubble_valid", {63'd0, bus.ExeResultQ102H.Valid}, 64'd0);

        // Back-to-back RAW hazard: SUB must see the ADD result, not the stale RF value.
        @(posedge Clock); #1;
        drive(ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0, 32'd5, 32'd7);
        @(posedge Clock); #1;
        drive(SUB, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 32'd0, 32'd0, 32'd5);
        @(negedge Clock);
        check("fwd_first", {32'd0, bus.ExeResultQ102H.Value}, 64'd12);
        @(posedge Clock); #1;
        drive(ADD, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge Clock);
        check("fwd_sub", {32'd0, bus.ExeResultQ102H.Value}, 64'd7);
        @(posedge Clock); #1;
        drive(ADD, 5'd1, 5'd1, 5'd5, 1'b0, 1'b0, 32'd0, 32'd1, 32'd1);
        @(posedge Clock); #1;
        drive(ADD, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0, 32'd100, 32'd0);
        @(posedge Clock); #1;
        idle();
        @(negedge Clock);
        check("no_fwd_without_wren", {32'd0, bus.ExeResultQ102H.Value}, 64'd100);
        @(posedge Clock); #1;

        // MUL latency and stall window.
        drive(MUL, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'd0, 32'h0000FFFF, 32'h00010001);
        stall_cnt = 0; lat = -1; held = 1'b1; got = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            st = bus.StallQ101H;
            if (held && st) stall_cnt++;
            if (lat < 0 && bus.ExeResultQ102H.Valid) begin
                lat = k;
                got = bus.ExeResultQ102H;
            end
            @(posedge Clock); #1;
            if (held && !st) begin
                idle();
                held = 1'b0;
            end
        end
        check("mul_stall_cycles", 64'(stall_cnt), 64'd32);
        check("mul_latency", 64'(lat), 64'd33);
        check("mul_result", {25'd0, got}, {25'd0, 1'b1, 1'b1, 5'd7, 32'hFFFFFFFF});

        // Reset in the middle of a multiply.
        drive(MUL, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'd0, 32'd3, 32'd5);
        repeat (11) @(posedge Clock);
        #1 Rst = 1'b1;
        idle();
        @(posedge Clock); #1 Rst = 1'b0;
        @(negedge Clock);
        check("rst_mul_stall", {63'd0, bus.StallQ101H}, 64'd0);
        check("rst_mul_result", {25'd0, bus.ExeResultQ102H}, 64'd0);
        nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (bus.ExeResultQ102H.Valid) nvalid++;
        end
        check("rst_mul_no_result", 64'(nvalid), 64'd0);
        @(posedge Clock); #1;
        drive(ADD, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd0, 32'd2, 32'd3);
        @(posedge Clock); #1;
        idle();
        @(negedge Clock);
        check("post_rst_add", {25'd0, bus.ExeResultQ102H}, {25'd0, 1'b1, 1'b1, 5'd9, 32'd5});
        @(posedge Clock); #1;

        // Random stream against an architectural register-file model.
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        rf_prev = rf;
        b2b = 1'b0;
        nissued = 0;
        nres = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.CtrlQ101H       = t_exe_ctrl'({$urandom, $urandom});
                bus.CtrlQ101H.Valid = 1'b0;
                @(posedge Clock); #1;
                b2b = 1'b0;
            end else begin
                t_alu_op     op;
                logic [4:0]  s1, s2, d;
                logic        we, ui;
                logic [31:0] imm, a, b, r1, r2, e;
                op  = t_alu_op'($urandom_range(0, 10));
                s1  = 5'($urandom_range(0, 7));
                s2  = 5'($urandom_range(0, 7));
                d   = 5'($urandom_range(0, 7));
                we  = ($urandom_range(0, 4) != 0);
                ui  = ($urandom_range(0, 3) == 0);
                imm = $urandom;
                drv = b2b ? rf_prev : rf;
                r1  = (s1 == 0) ? $urandom : drv[s1];
                r2  = (s2 == 0) ? $urandom : drv[s2];
                a   = rf[s1];
                b   = ui ? imm : rf[s2];
                e   = model(op, a, b);
                rf_prev = rf;
                if (we && d != 0) rf[d] = e;
                expq.push_back('{we, d, e});
                nissued++;
                drive(op, s1, s2, d, we, ui, imm, r1, r2);
                held = 1'b1;
                for (int g = 0; g < 100 && held; g++) begin
                    @(negedge Clock);
                    st = bus.StallQ101H;
                    @(posedge Clock); #1;
                    if (!st) held = 1'b0;
                end
                if (held) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_accept actual=stalled required=accepted");
                end
                b2b = 1'b1;
            end
        end
        idle();
        repeat (40) @(posedge Clock);
        @(negedge Clock);
        mon_en = 1'b0;
        check("rnd_pending", 64'(expq.size()), 64'd0);
        check("rnd_count", 64'(nres), 64'(nissued));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
